smul_umul: RTL and testbench
============================

SMUL_UMUL -- requirements
Module: smul_umul

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand and result width.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, meaning a request to begin a multiply.
REQ-005 SHALL have port is_signed, input, 1 bit, meaning 1 selects two's-complement (smul) and 0 selects unsigned (umul); sampled with start.
REQ-006 SHALL have ports a and b, inputs, W bits each, meaning the operands; sampled with start.
REQ-007 SHALL have port p, output, W bits, meaning the low W bits of the product.
REQ-008 SHALL have port ovf, output, 1 bit, meaning the full product is not representable in W bits for the selected mode.
REQ-009 SHALL have port busy, output, 1 bit, meaning an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when p and ovf become valid.

Function
REQ-011 SHALL accept start only when busy=0 and SHALL capture a, b and is_signed on that edge.
REQ-012 SHALL ignore start while busy=1, with no effect on the in-flight operation.
REQ-013 SHALL use an FSM with states IDLE, RUN and FIN: IDLE->RUN on an accepted start; RUN->FIN after W iterations; FIN->IDLE after one cycle.
REQ-014 SHALL compute by radix-2 shift-add over magnitudes, one bit per cycle.
REQ-015 SHALL, in signed mode, multiply the operand magnitudes and negate the 2W-bit product when sign(a) XOR sign(b); -2^(W-1) magnitude SHALL be handled as an unsigned W-bit value.
REQ-016 SHALL assert busy from the cycle after an accepted start through the FIN cycle.
REQ-017 SHALL pulse done for exactly one cycle, in FIN, W+1 cycles after the accepting edge.
REQ-018 SHALL update p and ovf only in FIN and hold them until the next FIN or reset.
REQ-019 SHALL set p to product[W-1:0], which is the wrap-around result for both modes.
REQ-020 SHALL set ovf in unsigned mode when product[2W-1:W]≠0.
REQ-021 SHALL set ovf in signed mode when product[2W-1:W-1] is not all-0 and not all-1.
REQ-022 SHALL treat a zero operand by the normal path, giving p=0, ovf=0 and the same latency; early termination is not permitted.

Reset
REQ-023 SHALL, on rst_n=0 and regardless of clk, force state IDLE and p=0, ovf=0, busy=0, done=0, p_hi=0, and clear all datapath registers.
REQ-024 SHALL abort any in-flight operation on reset mid-operation, with no done pulse afterward.
REQ-025 SHALL accept a start asserted on the first clock edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro SMUL_UMUL_HI_EN defined, add output port p_hi (W bits), holding product[2W-1:W] with the same timing and reset as p.
REQ-027 SHALL, without SMUL_UMUL_HI_EN, have no p_hi port and no other behavioural change.

Structure
REQ-028 SHALL define the default width constant MUL_W=32 and the FSM state enum {IDLE, RUN, FIN} in shared package mul_pkg.
REQ-029 SHALL place the iterative unsigned shift-add datapath in one sub-module, mul_core; sign handling, FSM and output registers stay in the top level.

Verification
REQ-030 SHALL cover: unsigned 5*6 and signed 5*6 -> p=30, ovf=0, done exactly W+1 cycles after start.
REQ-031 SHALL cover: unsigned 2*8 -> p=16; signed -2*8 -> p=0xFFFFFFF0 (-16), ovf=0, p_hi=0xFFFFFFFF when SMUL_UMUL_HI_EN is defined.
REQ-032 SHALL cover: signed -5*-5 -> p=25, ovf=0; unsigned 0xFFFFFFFB*0xFFFFFFFB -> p=25, ovf=1.
REQ-033 SHALL cover: signed 0x80000000*0xFFFFFFFF -> p=0x80000000, ovf=1; unsigned 0x10000*0x10000 -> p=0, ovf=1.
REQ-034 SHALL cover: start pulsed again while busy -> ignored, with the first result unchanged.
REQ-035 SHALL cover: rst_n=0 mid-RUN -> busy=0, p=0, ovf=0 immediately, and no done pulse afterward.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the iterative multiplier.
package mul_pkg;
  localparam int MUL_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;
endpackage

// File: rtl/mul_core.sv
// Unsigned radix-2 shift-add datapath; one multiplier bit retired per step.
module mul_core
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   ma,
  input  logic [W-1:0]   mb,
  output logic [2*W-1:0] prod
);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mc;
  logic [W-1:0]   mp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mc  <= '0;
      mp  <= '0;
    end else if (load) begin
      acc <= '0;
      mc  <= {{W{1'b0}}, ma};
      mp  <= mb;
    end else if (step) begin
      if (mp[0])
        acc <= acc + mc;
      mc <= mc << 1;
      mp <= mp >> 1;
    end
  end

  assign prod = acc;

endmodule

// File: rtl/smul_umul.sv
// Signed/unsigned iterative multiplier: sign handling, FSM, result regs.
// Define SMUL_UMUL_HI_EN to expose the upper product half on p_hi.
module smul_umul
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         ovf,
`ifdef SMUL_UMUL_HI_EN
  output logic [W-1:0] p_hi,
`endif
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           sgn;
  logic           accept;
  logic           step;
  logic           last;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] full;
  logic [W:0]     top;
  logic           ovf_n;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(W));
  assign step   = (state == RUN) && !last;

  // -2^(W-1) negates to itself, which is its correct unsigned magnitude
  assign ma = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
  assign mb = (is_signed && b[W-1]) ? (~b + 1'b1) : b;

  mul_core #(.W(W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (step),
    .ma    (ma),
    .mb    (mb),
    .prod  (prod)
  );

  assign full = neg ? (~prod + 1'b1) : prod;
  assign top  = full[2*W-1:W-1];

  always_comb begin
    ovf_n = 1'b0;
    if (sgn)
      ovf_n = !((&top) || (~|top));
    else
      ovf_n = |full[2*W-1:W];
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = RUN;
      RUN:  if (last) nxt = FIN;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      neg   <= 1'b0;
      sgn   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= '0;
        neg <= is_signed && (a[W-1] ^ b[W-1]);
        sgn <= is_signed;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (last) begin
      p   <= full[W-1:0];
      ovf <= ovf_n;
    end
  end

`ifdef SMUL_UMUL_HI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      p_hi <= '0;
    else if (last)
      p_hi <= full[2*W-1:W];
  end
`endif

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_smul_umul.sv
// Directed self-checking bench for smul_umul (W = 32).
module tb_smul_umul;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         ovf;
  logic         busy;
  logic         done;
`ifdef SMUL_UMUL_HI_EN
  logic [W-1:0] p_hi;
`endif

  int checks = 0;
  int errors = 0;

  smul_umul #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .p         (p),
    .ovf       (ovf),
`ifdef SMUL_UMUL_HI_EN
    .p_hi      (p_hi),
`endif
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op; accept edge is edge 0, done expected only after edge W+1.
  task automatic do_op(input string tag, input logic s,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] ep, input logic eo,
                       input logic [W-1:0] eh, input bit poke,
                       input bit rel);
    int lat;
    int pulses;
    lat = -1;
    pulses = 0;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    start = 1'b1;
    is_signed = s;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '0;
    b = '0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (poke && k == 5) begin
        start = 1'b1;
        is_signed = 1'b0;
        a = 32'd3;
        b = 32'd3;
      end
      if (poke && k == 6) start = 1'b0;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(W + 1));
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_p"}, 64'(p), 64'(ep));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`ifdef SMUL_UMUL_HI_EN
    chk({tag, "_hi"}, 64'(p_hi), 64'(eh));
`else
    if (eh !== eh) $display("unreachable");
`endif
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // first start right after reset release
    do_op("u5x6", 1'b0, 32'd5, 32'd6, 32'd30, 1'b0, 32'd0, 0, 1);
    do_op("s5x6", 1'b1, 32'd5, 32'd6, 32'd30, 1'b0, 32'd0, 0, 0);
    do_op("u2x8", 1'b0, 32'd2, 32'd8, 32'd16, 1'b0, 32'd0, 0, 0);
    do_op("sm2x8", 1'b1, 32'hFFFFFFFE, 32'd8, 32'hFFFFFFF0, 1'b0,
          32'hFFFFFFFF, 0, 0);
    do_op("sm5xm5", 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25, 1'b0,
          32'd0, 0, 0);
    do_op("uFBxFB", 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25, 1'b1,
          32'hFFFFFFF6, 0, 0);
    do_op("sminxm1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
          1'b1, 32'd0, 0, 0);
    do_op("u64k", 1'b0, 32'h00010000, 32'h00010000, 32'd0, 1'b1,
          32'd1, 0, 0);
    do_op("sm0", 1'b1, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 0, 0);
    // second start while busy must not disturb 7*9
    do_op("u7x9poke", 1'b0, 32'd7, 32'd9, 32'd63, 1'b0, 32'd0, 1, 0);

    // abort mid-RUN
    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b0;
    a = 32'd1000;
    b = 32'd1000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) dn++;
    end
    chk("abort_nodone", 64'(dn), 64'd0);

    // reset again, then start on the first edge after release
    @(negedge clk);
    rst_n = 1'b0;
    do_op("u3x4rel", 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 32'd0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
